// File: rtl/fixed_linear_acc.sv
// Fixed-point linear layer: dot product over IN_FEATURES in DEPTH beats, optional bias, round/ReLU/saturate.
// Latency: result valid one cycle after the last input beat (no bias) or after the bias handshake.
// Backpressure: inputs stall while data and weight are not both valid; the output holds until data_out_0_ready.
module fixed_linear_acc #(
    parameter int IN_WIDTH          = 8,
    parameter int IN_FRAC_WIDTH     = 4,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int WEIGHT_FRAC_WIDTH = 4,
    parameter int BIAS_WIDTH        = 8,
    parameter int BIAS_FRAC_WIDTH   = 4,
    parameter int OUT_WIDTH         = 8,
    parameter int OUT_FRAC_WIDTH    = 4,
    parameter int IN_FEATURES       = 4,
    parameter int IN_PAR            = 2,
    parameter int OUT_PAR           = 2,
    parameter int HAS_BIAS          = 1,
    parameter int RELU              = 0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [IN_PAR-1:0][IN_WIDTH-1:0]           data_in_0,
    input  logic                                      data_in_0_valid,
    output logic                                      data_in_0_ready,
    input  logic [OUT_PAR*IN_PAR-1:0][WEIGHT_WIDTH-1:0] weight,
    input  logic                                      weight_valid,
    output logic                                      weight_ready,
    input  logic [OUT_PAR-1:0][BIAS_WIDTH-1:0]        bias,
    input  logic                                      bias_valid,
    output logic                                      bias_ready,
    output logic [OUT_PAR-1:0][OUT_WIDTH-1:0]         data_out_0,
    output logic                                      data_out_0_valid,
    input  logic                                      data_out_0_ready
);

    localparam int DEPTH     = IN_FEATURES / IN_PAR;
    localparam int ACC_WIDTH = IN_WIDTH + WEIGHT_WIDTH + $clog2(IN_FEATURES) + 1;
    localparam int ACC_FRAC  = IN_FRAC_WIDTH + WEIGHT_FRAC_WIDTH;
    localparam int CNT_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BSHIFT    = ACC_FRAC - BIAS_FRAC_WIDTH;
    localparam int OSHIFT    = ACC_FRAC - OUT_FRAC_WIDTH;

    // Rounding/saturation arithmetic carries one extra bit so the half-LSB add cannot overflow.
    localparam logic signed [ACC_WIDTH:0] HALF =
        (OSHIFT > 0) ? (ACC_WIDTH+1)'(64'sd1 <<< ((OSHIFT > 0) ? OSHIFT - 1 : 0)) : '0;
    localparam logic signed [ACC_WIDTH:0] OMAX = (ACC_WIDTH+1)'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {S_ACCUM, S_BIAS, S_OUTPUT} state_t;

    state_t                      state, state_next;
    logic [CNT_W-1:0]            cnt;
    logic signed [ACC_WIDTH-1:0] acc      [OUT_PAR];
    logic signed [ACC_WIDTH-1:0] acc_next [OUT_PAR];
    logic signed [ACC_WIDTH-1:0] dot      [OUT_PAR];
    logic                        beat, bias_fire, first_beat, last_beat, enter_out;

    function automatic logic signed [ACC_WIDTH-1:0] mul_ext(input logic signed [IN_WIDTH-1:0] a,
                                                            input logic signed [WEIGHT_WIDTH-1:0] b);
        logic signed [IN_WIDTH+WEIGHT_WIDTH-1:0] p;
        p = a * b;
        return ACC_WIDTH'(p);
    endfunction

    // Bias is aligned to the accumulator's binary point before adding.
    function automatic logic signed [ACC_WIDTH-1:0] bias_ext(input logic signed [BIAS_WIDTH-1:0] b);
        logic signed [ACC_WIDTH-1:0] e;
        e = ACC_WIDTH'(b);
        return e <<< BSHIFT;
    endfunction

    // Round half up, optional ReLU, then clamp into the output range.
    function automatic logic [OUT_WIDTH-1:0] finish(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH:0] r;
        r = (ACC_WIDTH+1)'(a) + HALF;
        r = r >>> OSHIFT;
        if ((RELU != 0) && r[ACC_WIDTH]) r = '0;
        if (r > OMAX)      r = OMAX;
        else if (r < OMIN) r = OMIN;
        return r[OUT_WIDTH-1:0];
    endfunction

    assign beat       = (state == S_ACCUM) && data_in_0_valid && weight_valid;
    assign bias_fire  = (state == S_BIAS) && bias_valid;
    assign first_beat = (cnt == '0);
    assign last_beat  = (cnt == CNT_W'(DEPTH - 1));
    assign enter_out  = (state != S_OUTPUT) && (state_next == S_OUTPUT);

    // Per-channel dot product of this beat and the accumulator update (beat 0 loads, no clear cycle).
    always_comb begin
        for (int o = 0; o < OUT_PAR; o++) begin
            dot[o] = '0;
            for (int i = 0; i < IN_PAR; i++) begin
                dot[o] = dot[o] + mul_ext(data_in_0[i], weight[o*IN_PAR+i]);
            end
            acc_next[o] = acc[o];
            if (beat)           acc_next[o] = first_beat ? dot[o] : acc[o] + dot[o];
            else if (bias_fire) acc_next[o] = acc[o] + bias_ext(bias[o]);
        end
    end

    // State register, beat counter, accumulators and the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_ACCUM;
            cnt        <= '0;
            data_out_0 <= '0;
            for (int o = 0; o < OUT_PAR; o++) acc[o] <= '0;
        end else begin
            state <= state_next;
            if (beat) cnt <= last_beat ? '0 : cnt + 1'b1;
            for (int o = 0; o < OUT_PAR; o++) begin
                acc[o] <= acc_next[o];
                if (enter_out) data_out_0[o] <= finish(acc_next[o]);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_ACCUM:  if (beat && last_beat) state_next = (HAS_BIAS != 0) ? S_BIAS : S_OUTPUT;
            S_BIAS:   if (bias_valid) state_next = S_OUTPUT;
            S_OUTPUT: if (data_out_0_ready) state_next = S_ACCUM;
            default:  state_next = S_ACCUM;
        endcase
    end

    // Handshake outputs decoded from the current state; each input ready waits on its partner's valid.
    always_comb begin
        data_in_0_ready  = (state == S_ACCUM) && weight_valid;
        weight_ready     = (state == S_ACCUM) && data_in_0_valid;
        bias_ready       = (state == S_BIAS);
        data_out_0_valid = (state == S_OUTPUT);
    end

endmodule

// File: doc/fixed_linear_acc.md
FIXED_LINEAR_ACC -- requirements
Module: fixed_linear_acc

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- IN_WIDTH, 8: data_in_0 element width (signed).
- IN_FRAC_WIDTH, 4: data_in_0 fraction bits.
- WEIGHT_WIDTH, 8: weight element width (signed).
- WEIGHT_FRAC_WIDTH, 4: weight fraction bits.
- BIAS_WIDTH, 8: bias element width (signed).
- BIAS_FRAC_WIDTH, 4: bias fraction bits.
- OUT_WIDTH, 8: output element width (signed).
- OUT_FRAC_WIDTH, 4: output fraction bits.
- IN_FEATURES, 4: dot-product length.
- IN_PAR, 2: input elements per beat; divides IN_FEATURES.
- OUT_PAR, 2: output channels computed concurrently.
- HAS_BIAS, 1: bias add enable.
- RELU, 0: 1 clamps negative results to zero.

REQ-002 SHALL have ports (name, direction, width, meaning); clock and reset first:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- data_in_0, in, IN_WIDTH x IN_PAR: input segment.
- data_in_0_valid / data_in_0_ready, in / out, 1: input handshake.
- weight, in, WEIGHT_WIDTH x OUT_PAR*IN_PAR: weight block; element [o*IN_PAR+i] multiplies data_in_0[i] for channel o.
- weight_valid / weight_ready, in / out, 1: weight handshake.
- bias, in, BIAS_WIDTH x OUT_PAR: per-channel bias.
- bias_valid / bias_ready, in / out, 1: bias handshake.
- data_out_0, out, OUT_WIDTH x OUT_PAR: result.
- data_out_0_valid / data_out_0_ready, out / in, 1: output handshake.

Function
REQ-003 SHALL define DEPTH = IN_FEATURES/IN_PAR, ACC_WIDTH = IN_WIDTH+WEIGHT_WIDTH+clog2(IN_FEATURES)+1 and ACC_FRAC = IN_FRAC_WIDTH+WEIGHT_FRAC_WIDTH.
REQ-004 SHALL use a three-state FSM: ACCUM, BIAS, OUTPUT; ACCUM after reset.
REQ-005 SHALL, in ACCUM, drive data_in_0_ready = weight_valid and weight_ready = data_in_0_valid; both SHALL be 0 in other states.
REQ-006 SHALL consume a beat only when data_in_0_valid and weight_valid are both high in ACCUM.
REQ-007 SHALL count beats 0..DEPTH-1 and wrap to 0 after the last beat.
REQ-008 SHALL, per channel o, load acc[o] = sum_i data[i]*w[o*IN_PAR+i] on beat 0 and add that sum on later beats. There is no separate clear cycle.
REQ-009 SHALL, on the last beat, go to BIAS if HAS_BIAS=1, else to OUTPUT.
REQ-010 SHALL assert bias_ready only in BIAS. Bias offered in other states is not consumed.
REQ-011 SHALL, on a bias handshake, add bias[o] to acc[o] after sign-extending and left-shifting it to ACC_FRAC, then go to OUTPUT.
REQ-012 SHALL, on entry to OUTPUT, register each channel as follows:
- round to OUT_FRAC_WIDTH by adding half an LSB, then arithmetic shift right (round half up);
- if RELU=1, force a negative result to 0;
- saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-013 SHALL assert data_out_0_valid exactly in OUTPUT. data_out_0_valid SHALL rise the cycle after the final input beat (HAS_BIAS=0) or after the bias handshake (HAS_BIAS=1).
REQ-014 SHALL hold data_out_0 stable while data_out_0_valid=1 and data_out_0_ready=0.
REQ-015 SHALL return to ACCUM the cycle after a data_out_0_valid & data_out_0_ready handshake; no input is accepted in that handshake cycle.
REQ-016 SHALL support DEPTH=1, where every beat is both first and last.
REQ-017 SHALL allow data_in_0_valid and weight_valid to arrive in any order and on different cycles, and SHALL consume nothing until both are high.

Reset
REQ-018 SHALL, on rst, immediately and asynchronously:
- set state ACCUM and beat counter 0;
- drive data_out_0_valid=0, bias_ready=0 and data_out_0 all-zero.
REQ-019 SHALL discard any partial accumulation or pending output on reset mid-operation; the next beat after reset is beat 0.

Verification
All scenarios use default parameters unless noted; values are hex.
REQ-020 Basic: x all 10 (1.0), row0 w all 10, row1 w all 08, bias {00,00} -> data_out_0 = {40, 20} one cycle after the bias handshake.
REQ-021 Saturation: x all 40, w all 40 -> {7F, 7F}; x all 40, w all C0 -> {80, 80}.
REQ-022 ReLU: x all 10, w all F0, bias 0 -> RELU=0 gives {C0, C0}; RELU=1 gives {00, 00}.
REQ-023 Rounding: lane0 x=01, w=08, all other elements 00, bias 0 -> output 01 (0.03125 rounds half up to 0.0625).
REQ-024 Backpressure: hold data_out_0_ready=0 for 5 cycles in OUTPUT -> data_out_0 is unchanged, data_in_0_ready=0 and bias_ready=0 throughout; bias_valid held high during ACCUM is not consumed.
REQ-025 Reset mid-operation: assert rst after one beat of x=7F, then send the full REQ-020 stimulus -> output {40, 20}, with no residue from the pre-reset beat.
